tone_divider: RTL
=================

TONE_DIVIDER -- requirements
Module: tone_divider

Interface
REQ-001 SHALL provide parameter HALF_W, default 19, width of the half-period count in clock cycles.
REQ-002 SHALL provide port CLK_50_MHz  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port period_in  input  HALF_W  requested half-period P in clock cycles; P=0 means mute.
REQ-005 SHALL provide port period_valid  input  1  period_in offered this cycle.
REQ-006 SHALL provide port period_ready  output  1  block can accept a period this cycle.
REQ-007 SHALL provide port enable  input  1  count advance enable; low freezes the divider.
REQ-008 SHALL provide port tone_out  output  1  square-wave audio output.
REQ-009 SHALL provide port edge_tick  output  1  one-cycle pulse per tone_out toggle.
REQ-010 SHALL provide port busy  output  1  high while in state RUN.

Function
REQ-011 SHALL hold registers: state {IDLE, RUN}, active (HALF_W), cnt (HALF_W), pend_val (HALF_W), pend flag, tone_out, edge_tick.
REQ-012 SHALL register all outputs; period_ready = !pend, busy = (state==RUN), both derived from registers only.
REQ-013 SHALL accept a period on any edge where period_valid && period_ready.
REQ-014 Accept P=0 in any state: next cycle state=IDLE, tone_out=0, cnt=0, pend=0, edge_tick=0, no toggle.
REQ-015 Accept P!=0 in IDLE: next cycle active=P, cnt=P-1, state=RUN, tone_out unchanged (0).
REQ-016 Accept P!=0 in RUN: pend_val=P, pend=1; active unchanged until next boundary.
REQ-017 Boundary = RUN && enable && cnt==0.
REQ-018 At a boundary: tone_out inverts, edge_tick=1 next cycle; if pend, active=pend_val, cnt=pend_val-1, pend=0; else cnt=active-1.
REQ-019 RUN && enable && cnt!=0: cnt decrements by 1; edge_tick=0.
REQ-020 enable low: cnt, tone_out, active, state frozen; edge_tick=0; acceptance still permitted.
REQ-021 With enable held high, tone_out SHALL toggle every P cycles (full period 2P); first toggle on the P-th edge after the acceptance edge.
REQ-022 P=1 SHALL toggle tone_out every cycle; P=2^HALF_W-1 SHALL not wrap or overflow cnt.
REQ-023 A P!=0 accepted on the same edge as a boundary SHALL be held pending and applied at the following boundary.
REQ-024 In IDLE tone_out SHALL be 0 and edge_tick SHALL be 0 regardless of enable.
REQ-025 period_in SHALL be ignored whenever period_ready is low (no overwrite of pend_val).
REQ-026 No combinational path from any input to any output.

Reset
REQ-027 reset high at an edge SHALL set state=IDLE, active=0, cnt=0, pend_val=0, pend=0, tone_out=0, edge_tick=0 next cycle.
REQ-028 reset SHALL take priority over acceptance, boundary and enable in the same cycle; period_valid during reset SHALL be discarded.
REQ-029 After reset deasserts: period_ready=1, busy=0, tone_out=0.

Verification
REQ-030 Reset, accept P=5, enable=1 -> busy=1 next cycle; tone_out rises 5 edges after acceptance, then toggles every 5 cycles; edge_tick pulses exactly once per toggle.
REQ-031 Running P=5, accept P=3 mid half-period -> period_ready low until next boundary; current half-period completes at 5, subsequent half-periods are 3.
REQ-032 Running P=4, drop enable for 7 cycles mid half-period -> tone_out and cnt frozen, no edge_tick; resumes and completes the remaining count.
REQ-033 Running P=6, accept P=0 -> next cycle tone_out=0, busy=0, period_ready=1, no further edge_tick.
REQ-034 Running P=2, assert reset with period_valid=1 and P=7 -> all outputs at reset values next cycle, P=7 not captured.
REQ-035 Accept P=1, then P=2^HALF_W-1 offered on the boundary edge -> P=1 toggling continues one more half-period, then half-periods of 2^HALF_W-1 with no wrap.

Source files
------------

// File: rtl/tone_divider.sv
// Programmable square-wave tone generator: tone_out toggles every P enabled cycles.
// A new period offered while running is held pending and takes effect at the next toggle.
module tone_divider #(
  parameter int HALF_W = 19
) (
  input  logic              CLK_50_MHz,
  input  logic              reset,
  input  logic [HALF_W-1:0] period_in,
  input  logic              period_valid,
  output logic              period_ready,
  input  logic              enable,
  output logic              tone_out,
  output logic              edge_tick,
  output logic              busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state;
  logic [HALF_W-1:0] active;
  logic [HALF_W-1:0] cnt;
  logic [HALF_W-1:0] pend_val;
  logic              pend;
  logic              accept;

  localparam logic [HALF_W-1:0] ONE = HALF_W'(1);

  assign accept       = period_valid && !pend;
  assign period_ready = !pend;
  assign busy         = (state == RUN);

  always_ff @(posedge CLK_50_MHz) begin
    if (reset) begin
      state     <= IDLE;
      active    <= '0;
      cnt       <= '0;
      pend_val  <= '0;
      pend      <= 1'b0;
      tone_out  <= 1'b0;
      edge_tick <= 1'b0;
    end else begin
      edge_tick <= 1'b0;
      if (accept && period_in == '0) begin
        // Mute wins over everything, including a boundary on this edge.
        state    <= IDLE;
        tone_out <= 1'b0;
        cnt      <= '0;
        pend     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              active <= period_in;
              cnt    <= period_in - ONE;
              state  <= RUN;
            end
          end
          RUN: begin
            if (enable) begin
              if (cnt == '0) begin
                tone_out  <= ~tone_out;
                edge_tick <= 1'b1;
                if (pend) begin
                  active <= pend_val;
                  cnt    <= pend_val - ONE;
                  pend   <= 1'b0;
                end else begin
                  cnt <= active - ONE;
                end
              end else begin
                cnt <= cnt - ONE;
              end
            end
            // accept implies !pend, so this never collides with the pend clear above.
            if (accept) begin
              pend_val <= period_in;
              pend     <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
